postadder_normalizer: RTL and testbench
=======================================

Name: postadder_normalizer

Overview:
- Back end of the FP adder datapath: takes the raw sum/difference of aligned mantissas with the common exponent, normalizes, rounds and packs an IEEE-style result.
- Iterative, multi-cycle engine with valid/ready handshakes on both sides.
- Consumes the sticky (loss) bit produced during alignment.

Parameters:
- EXP_SIZE, `EXP_SIZE (8): exponent field width.
- MANTIS_SIZE, `MANTIS_SIZE (23): stored fraction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an input (IDLE only).
- in_sign  in  1  sign of result.
- in_exp  in  EXP_SIZE  common exponent (biased).
- in_mantis  in  MANTIS_SIZE+4  {carry, hidden, fraction, guard, round}.
- in_sticky  in  1  OR of bits lost during alignment.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- out_result  out  1+EXP_SIZE+MANTIS_SIZE  packed {sign, exp, fraction}.
- out_zero  out  1  result is zero.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result flushed to zero.

Behaviour:
- Reset (synchronous, active-high): state IDLE; in_ready=1; out_valid=0; out_result=0; all flags 0. Reset mid-operation abandons the operation; no output is produced.
- States: IDLE, NORM, ROUND, DONE.
- IDLE
  - in_ready=1. On in_valid&in_ready, capture sign, exp, mantis and sticky.
  - If mantis==0 and sticky==0: result +0, out_zero=1, go to DONE.
  - If in_exp==0 with nonzero mantis: out_underflow=1, result {sign,0,0}, go to DONE.
  - Otherwise go to NORM.
- NORM: one action per cycle.
  - Carry set: shift right 1, sticky|=shifted-out bit, exp+1, then go to ROUND.
  - Carry clear, hidden set: go to ROUND.
  - Carry clear, hidden clear, exp>1: shift left 1 (zero fill at round bit), exp-1, stay in NORM.
  - Carry clear, hidden clear, exp==1: out_underflow=1, result {sign,0,0}, go to DONE.
- ROUND: round to nearest, ties to even.
  - Definitions: g=guard, r=round|sticky, lsb=fraction[0]; inc=g&(r|lsb).
  - Add inc to {hidden,fraction}. If this carries out: fraction=0, exp+1.
  - Overflow: if exp reaches all-ones (after NORM or rounding), result={sign, all-ones, 0} and out_overflow=1.
  - Go to DONE.
- DONE
  - out_valid=1; out_result and flags stable.
  - On out_ready: out_valid=0, flags cleared, go to IDLE.
  - No new input is accepted in DONE (in_ready=0), so no overlap with a pending result.
- Latency (capture edge to out_valid): 3 cycles plus 1 per left shift; zero/underflow-at-entry cases take 1 cycle.
- All exponent arithmetic uses EXP_SIZE+1 bits internally to detect wrap; never wraps silently.

Optional Feature:
- Macro: POSTADDER_LZC_EN.
- Defined: NORM uses a combinational leading-zero counter and performs the full left shift in one cycle.
  - Shift is clamped to exp-1; if clamped with hidden still clear, underflow.
  - Latency is fixed at 3 cycles for all non-zero cases.
- Undefined: iterative one-bit-per-cycle shifting as above.
- Results and flags are identical in both builds.

Test Plan:
- 1.5+1.5: exp=127, mantis={1,1,0...0,00}, sticky=0 -> out_result=0x40400000, no flags, latency 3.
- 1.0-0.75: exp=127, mantis={0,0,1,0...0,00} -> 0x3E800000 after 2 left shifts, latency 5 (3 with LZC_EN).
- Tie-to-even with carry: exp=127, mantis={0,1,all-ones,1,0}, sticky=0 -> 0x40000000. Same inputs with fraction lsb=0 -> no increment.
- Overflow: exp=254, carry set -> 0x7F800000 with out_overflow=1. Exact zero: mantis=0, sticky=0 -> 0x00000000, out_zero=1, latency 1.
- Underflow: exp=1, mantis={0,0,0...01,00} -> result 0, out_underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_result stable, in_ready=0. Assert rst in NORM -> next cycle IDLE, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/postadder_normalizer_if.sv
// Handshake bundle for postadder_normalizer: operand side (in_*) and result side (out_*).
interface postadder_normalizer_if #(
    parameter int unsigned EXP_SIZE    = 8,
    parameter int unsigned MANTIS_SIZE = 23
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_sign;
    logic [EXP_SIZE-1:0]           in_exp;
    logic [MANTIS_SIZE+3:0]        in_mantis;
    logic                          in_sticky;
    logic                          out_valid;
    logic                          out_ready;
    logic [EXP_SIZE+MANTIS_SIZE:0] out_result;
    logic                          out_zero;
    logic                          out_overflow;
    logic                          out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mantis, in_sticky, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mantis, in_sticky, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_overflow, out_underflow
    );
endinterface

// File: rtl/postadder_normalizer.sv
// FP adder back end: normalize, round-to-nearest-even and pack the aligned mantissa sum.
// Optional macro POSTADDER_LZC_EN: single-cycle leading-zero normalization instead of 1 bit/cycle.
module postadder_normalizer #(
    parameter int unsigned EXP_SIZE    = 8,
    parameter int unsigned MANTIS_SIZE = 23
) (
    input logic                   clk,
    input logic                   rst,
    postadder_normalizer_if.slave bus
);
    localparam int unsigned MantisW = MANTIS_SIZE + 4;
    localparam int unsigned ExpW    = EXP_SIZE + 1;
    localparam int unsigned ResW    = 1 + EXP_SIZE + MANTIS_SIZE;
    localparam logic [ExpW-1:0] ExpMax = {1'b0, {EXP_SIZE{1'b1}}};
    localparam logic [ExpW-1:0] ExpOne = ExpW'(1);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e              state_q;
    logic                sign_q;
    logic [ExpW-1:0]     exp_q;
    logic [MantisW-1:0]  man_q;
    logic                sticky_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [ResW-1:0]     result_q;
    logic                zero_q;
    logic                ovf_q;
    logic                unf_q;

    logic                   rnd_inc;
    logic                   rnd_carry;
    logic [MANTIS_SIZE-1:0] rnd_frac_raw;
    logic [MANTIS_SIZE-1:0] rnd_frac;
    logic [ExpW-1:0]        rnd_exp;

    // Hidden bit is always 1 in ROUND, so a carry out of the fraction is the carry out of
    // {hidden, fraction}.
    always_comb begin
        rnd_inc = man_q[1] & (man_q[0] | sticky_q | man_q[2]);
        {rnd_carry, rnd_frac_raw} = {1'b0, man_q[MantisW-3:2]} +
                                    {{MANTIS_SIZE{1'b0}}, rnd_inc};
        rnd_frac = rnd_carry ? '0 : rnd_frac_raw;
        rnd_exp  = exp_q + ExpW'(rnd_carry);
    end

`ifdef POSTADDER_LZC_EN
    logic [ExpW-1:0] lz_cnt;
    logic [ExpW-1:0] lz_shamt;
    logic            lz_clamp;

    // Shifts needed to bring the leading one up to the hidden position; clamped at exp-1.
    always_comb begin
        lz_cnt = ExpW'(MantisW - 1);
        for (int i = 0; i < int'(MantisW) - 1; i++) begin
            if (man_q[i]) lz_cnt = ExpW'(int'(MantisW) - 2 - i);
        end
        lz_clamp = lz_cnt > (exp_q - ExpOne);
        lz_shamt = lz_clamp ? (exp_q - ExpOne) : lz_cnt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        sign_q     <= bus.in_sign;
                        exp_q      <= {1'b0, bus.in_exp};
                        man_q      <= bus.in_mantis;
                        sticky_q   <= bus.in_sticky;
                        in_ready_q <= 1'b0;
                        if (bus.in_mantis == '0 && !bus.in_sticky) begin
                            result_q    <= '0;
                            zero_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else if (bus.in_exp == '0) begin
                            result_q    <= {bus.in_sign, {(ResW-1){1'b0}}};
                            unf_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            state_q <= StNorm;
                        end
                    end
                end
                StNorm: begin
                    if (man_q[MantisW-1]) begin
                        man_q    <= man_q >> 1;
                        sticky_q <= sticky_q | man_q[0];
                        exp_q    <= exp_q + ExpOne;
                        state_q  <= StRound;
                    end else if (man_q[MantisW-2]) begin
                        state_q <= StRound;
`ifdef POSTADDER_LZC_EN
                    end else if (!lz_clamp) begin
                        man_q   <= man_q << lz_shamt;
                        exp_q   <= exp_q - lz_shamt;
                        state_q <= StRound;
`else
                    end else if (exp_q > ExpOne) begin
                        man_q <= {man_q[MantisW-2:0], 1'b0};
                        exp_q <= exp_q - ExpOne;
`endif
                    end else begin
                        result_q    <= {sign_q, {(ResW-1){1'b0}}};
                        unf_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StRound: begin
                    if (rnd_exp >= ExpMax) begin
                        result_q <= {sign_q, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};
                        ovf_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_q, rnd_exp[EXP_SIZE-1:0], rnd_frac};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        zero_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        unf_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = result_q;
    assign bus.out_zero      = zero_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_postadder_normalizer.sv
// Directed self-checking bench for postadder_normalizer (single precision configuration).
module tb_postadder_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef POSTADDER_LZC_EN
    localparam int SubLat = 3;
    localparam int StkLat = 2;
`else
    localparam int SubLat = 5;
    localparam int StkLat = 4;
`endif

    postadder_normalizer_if #(.EXP_SIZE(8), .MANTIS_SIZE(23)) bus ();

    postadder_normalizer #(.EXP_SIZE(8), .MANTIS_SIZE(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // flags are {zero, overflow, underflow}
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [26:0] m, input logic st, input logic [31:0] exp_res,
                          input logic [2:0] exp_flags, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_mantis = m;
        bus.in_sticky = st;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(bus.out_result), 64'(exp_res));
        check({tag, " flags"}, 64'({bus.out_zero, bus.out_overflow, bus.out_underflow}),
              64'(exp_flags));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " hold result"}, 64'(bus.out_result), 64'(exp_res));
            check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " valid drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, " flags clear"},
              64'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mantis = '0;
        bus.in_sticky = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", 64'(bus.out_result), 64'd0);
        check("reset flags", 64'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 64'd0);
        rst = 1'b0;

        run_op("add 1.5+1.5", 1'b0, 8'd127, {1'b1, 1'b1, 23'h0, 2'b00}, 1'b0,
               32'h4040_0000, 3'b000, 3, 0);
        run_op("sub 1.0-0.75", 1'b0, 8'd127, {1'b0, 1'b0, 23'h20_0000, 2'b00}, 1'b0,
               32'h3E80_0000, 3'b000, SubLat, 0);
        run_op("tie even carry", 1'b0, 8'd127, {1'b0, 1'b1, 23'h7F_FFFF, 2'b10}, 1'b0,
               32'h4000_0000, 3'b000, 3, 0);
        run_op("tie even keep", 1'b0, 8'd127, {1'b0, 1'b1, 23'h7F_FFFE, 2'b10}, 1'b0,
               32'h3FFF_FFFE, 3'b000, 3, 0);
        run_op("tie lsb0 no inc", 1'b0, 8'd127, {1'b0, 1'b1, 23'h0, 2'b10}, 1'b0,
               32'h3F80_0000, 3'b000, 3, 0);
        run_op("sticky round up", 1'b0, 8'd127, {1'b0, 1'b1, 23'h0, 2'b10}, 1'b1,
               32'h3F80_0001, 3'b000, 3, 0);
        run_op("overflow carry", 1'b0, 8'd254, {1'b1, 1'b0, 23'h0, 2'b00}, 1'b0,
               32'h7F80_0000, 3'b010, 3, 0);
        run_op("overflow round", 1'b1, 8'd254, {1'b0, 1'b1, 23'h7F_FFFF, 2'b11}, 1'b0,
               32'hFF80_0000, 3'b010, 3, 0);
        run_op("exact zero", 1'b1, 8'd100, 27'h0, 1'b0,
               32'h0000_0000, 3'b100, 1, 0);
        run_op("underflow exp1", 1'b0, 8'd1, {1'b0, 1'b0, 23'h1, 2'b00}, 1'b0,
               32'h0000_0000, 3'b001, 2, 0);
        run_op("underflow exp0", 1'b1, 8'd0, {1'b0, 1'b1, 23'h0, 2'b00}, 1'b0,
               32'h8000_0000, 3'b001, 1, 0);
        run_op("sticky only", 1'b0, 8'd3, 27'h0, 1'b1,
               32'h0000_0000, 3'b001, StkLat, 0);
        run_op("backpressure", 1'b1, 8'd127, {1'b1, 1'b1, 23'h0, 2'b00}, 1'b0,
               32'hC040_0000, 3'b000, 3, 5);

        // Reset while the engine is normalizing.
        @(negedge clk);
        bus.in_sign   = 1'b0;
        bus.in_exp    = 8'd127;
        bus.in_mantis = {1'b0, 1'b0, 23'h20_0000, 2'b00};
        bus.in_sticky = 1'b0;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst norm in_ready", 64'(bus.in_ready), 64'd1);
        check("rst norm out_valid", 64'(bus.out_valid), 64'd0);
        repeat (6) @(negedge clk);
        check("rst norm no output", 64'(bus.out_valid), 64'd0);

        run_op("after reset", 1'b0, 8'd127, {1'b1, 1'b1, 23'h0, 2'b00}, 1'b0,
               32'h4040_0000, 3'b000, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
